// File: rtl/marauder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : marauder_pkg
// Brief    : Shared types and instruction-field constants for marauder_seq.
// Revision : 1.0 - initial release
// ============================================================================
package marauder_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_ALU  = 2'b00,
        K_LDI  = 2'b01,
        K_BR   = 2'b10,
        K_HALT = 2'b11
    } kind_t;

    // Instruction field positions
    localparam int KIND_HI    = 15;
    localparam int KIND_LO    = 14;
    localparam int ALU_OP_HI  = 13;
    localparam int ALU_OP_LO  = 11;
    localparam int ALU_A_HI   = 10;
    localparam int ALU_A_LO   = 8;
    localparam int ALU_B_HI   = 7;
    localparam int ALU_B_LO   = 5;
    localparam int ALU_BANK   = 4;
    localparam int ALU_IDX_HI = 3;
    localparam int ALU_IDX_LO = 1;
    localparam int LDI_BANK   = 13;
    localparam int LDI_IDX_HI = 12;
    localparam int LDI_IDX_LO = 10;
    localparam int IMM_HI     = 7;
    localparam int IMM_LO     = 0;
    localparam int BR_FLAG    = 13;

    // Parked read select keeps the register file's zero/RNG selects untouched
    localparam logic [2:0]  IDLE_SEL = 3'b010;
    localparam logic        BANK_A   = 1'b0;
    localparam logic        BANK_B   = 1'b1;
    localparam logic [15:0] IR_RESET = 16'hC000;

    // Register-file write select: {3'b000, bank, idx}
    function automatic logic [6:0] wrt_select(input logic bank, input logic [2:0] idx);
        return {3'b000, bank, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/marauder_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : marauder_seq_if
// Brief    : Sequencer bus: ROM fetch, ALU results, register-file controls.
// Revision : 1.0 - initial release
// ============================================================================
interface marauder_seq_if #(
    parameter int PC_W = 8,
    parameter int IW   = 16
);
    logic            start;
    logic [PC_W-1:0] instr_addr;
    logic [IW-1:0]   instr_rdata;
    logic [7:0]      alu_c;
    logic            alu_zero;
    logic            alu_carry;
    logic [2:0]      opcode;
    logic [2:0]      rd_slct_a;
    logic [2:0]      rd_slct_b;
    logic [6:0]      wrt_slct;
    logic            wrtnbl;
    logic [7:0]      data_in;
    logic            busy;
    logic            halted;
    logic            zero_flag;
    logic            carry_flag;
    logic [15:0]     retired;

    modport master (
        input  start, instr_rdata, alu_c, alu_zero, alu_carry,
        output instr_addr, opcode, rd_slct_a, rd_slct_b, wrt_slct, wrtnbl,
               data_in, busy, halted, zero_flag, carry_flag, retired
    );

    modport slave (
        output start, instr_rdata, alu_c, alu_zero, alu_carry,
        input  instr_addr, opcode, rd_slct_a, rd_slct_b, wrt_slct, wrtnbl,
               data_in, busy, halted, zero_flag, carry_flag, retired
    );
endinterface
`default_nettype wire

// File: rtl/marauder_seq_decode.sv
`default_nettype none
// ============================================================================
// Module   : marauder_decode
// Brief    : Pure combinational instruction decoder for marauder_seq.
// Revision : 1.0 - initial release
// ============================================================================
module marauder_decode
    import marauder_pkg::*;
#(
    parameter int IW = 16
) (
    input  wire logic [IW-1:0] ir,
    output kind_t              kind,
    output logic [2:0]         opcode,
    output logic [2:0]         sel_a,
    output logic [2:0]         sel_b,
    output logic               wr_bank,
    output logic [2:0]         wr_idx,
    output logic [7:0]         imm,
    output logic               br_on_carry
);

    // Field extraction; the write target comes from different bits for ALU and LDI
    always_comb begin
        kind        = kind_t'(ir[KIND_HI:KIND_LO]);
        opcode      = ir[ALU_OP_HI:ALU_OP_LO];
        sel_a       = ir[ALU_A_HI:ALU_A_LO];
        sel_b       = ir[ALU_B_HI:ALU_B_LO];
        imm         = ir[IMM_HI:IMM_LO];
        br_on_carry = ir[BR_FLAG];
        if (kind == K_LDI) begin
            wr_bank = ir[LDI_BANK] ? BANK_B : BANK_A;
            wr_idx  = ir[LDI_IDX_HI:LDI_IDX_LO];
        end else begin
            wr_bank = ir[ALU_BANK] ? BANK_B : BANK_A;
            wr_idx  = ir[ALU_IDX_HI:ALU_IDX_LO];
        end
    end

endmodule
`default_nettype wire

// File: rtl/marauder_seq.sv
`default_nettype none
// ============================================================================
// Module   : marauder_seq
// Brief    : Three-cycle instruction sequencer driving register file and ALU.
// Revision : 1.0 - initial release
// ============================================================================
module marauder_seq
    import marauder_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IW   = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    marauder_seq_if.master bus
);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [IW-1:0]   r_ir;
    logic            r_zero;
    logic            r_carry;
    logic [15:0]     r_retired;

    kind_t           w_kind;
    logic [2:0]      w_opcode;
    logic [2:0]      w_sel_a;
    logic [2:0]      w_sel_b;
    logic            w_bank;
    logic [2:0]      w_idx;
    logic [7:0]      w_imm;
    logic            w_br_on_carry;
    logic            w_taken;
    logic [PC_W-1:0] w_pc_inc;

    marauder_decode #(.IW(IW)) u_decode (
        .ir          (r_ir),
        .kind        (w_kind),
        .opcode      (w_opcode),
        .sel_a       (w_sel_a),
        .sel_b       (w_sel_b),
        .wr_bank     (w_bank),
        .wr_idx      (w_idx),
        .imm         (w_imm),
        .br_on_carry (w_br_on_carry)
    );

    assign w_taken  = w_br_on_carry ? r_carry : r_zero;
    assign w_pc_inc = r_pc + PC_W'(1);

    // Sequencer FSM: program counter, instruction latch, flags and retire count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_ir      <= IR_RESET;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        r_pc    <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_LATCH;
                S_LATCH: begin
                    r_ir    <= bus.instr_rdata;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_retired <= r_retired + 16'd1;
                    case (w_kind)
                        K_ALU: begin
                            r_zero  <= bus.alu_zero;
                            r_carry <= bus.alu_carry;
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end
                        K_LDI: begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end
                        K_BR: begin
                            r_pc    <= w_taken ? PC_W'(w_imm) : w_pc_inc;
                            r_state <= S_FETCH;
                        end
                        default: r_state <= S_HALT;
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Register-file/ALU controls: decoded only in EXEC, parked everywhere else.
    // data_in must follow alu_c combinationally because the ALU result only
    // exists once the EXEC selects are driven.
    always_comb begin
        bus.opcode    = 3'b000;
        bus.rd_slct_a = IDLE_SEL;
        bus.rd_slct_b = IDLE_SEL;
        bus.wrt_slct  = 7'h00;
        bus.wrtnbl    = 1'b0;
        bus.data_in   = 8'h00;
        if (r_state == S_EXEC) begin
            case (w_kind)
                K_ALU: begin
                    bus.opcode    = w_opcode;
                    bus.rd_slct_a = w_sel_a;
                    bus.rd_slct_b = w_sel_b;
                    bus.wrt_slct  = wrt_select(w_bank, w_idx);
                    bus.wrtnbl    = 1'b1;
                    bus.data_in   = bus.alu_c;
                end
                K_LDI: begin
                    bus.wrt_slct  = wrt_select(w_bank, w_idx);
                    bus.wrtnbl    = 1'b1;
                    bus.data_in   = w_imm;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_addr = r_pc;
    assign bus.busy       = (r_state == S_FETCH) || (r_state == S_LATCH) || (r_state == S_EXEC);
    assign bus.halted     = (r_state == S_HALT);
    assign bus.zero_flag  = r_zero;
    assign bus.carry_flag = r_carry;
    assign bus.retired    = r_retired;

endmodule
`default_nettype wire

// File: doc/marauder_seq.md
# marauder_seq

Instruction sequencer that drives the ALU register file and ALU. It fetches 16-bit instructions from a synchronous program ROM and decodes them into register-file read selects, ALU opcode, write select, write enable and write data. It captures the ALU zero/carry flags and uses them for conditional branches. It sits directly upstream of the register file: its outputs feed the register file's `rd_slct_a`, `rd_slct_b`, `wrt_slct`, `wrtnbl` and `data_in`, and its `opcode` output feeds the ALU.

## Interface
Parameters:
- PC_W, 8, program counter / ROM address width
- IW, 16, instruction width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin execution at pc 0; ignored unless in IDLE or HALT
- instr_addr  out  PC_W  ROM address
- instr_rdata  in  IW  ROM data, valid one cycle after instr_addr
- alu_c  in  8  ALU result
- alu_zero  in  1  ALU zero flag
- alu_carry  in  1  ALU carry flag
- opcode  out  3  ALU opcode
- rd_slct_a  out  3  bank-A read select
- rd_slct_b  out  3  bank-B read select
- wrt_slct  out  7  {3'b000, bank, idx}; bank 0 = A, 1 = B
- wrtnbl  out  1  register write enable
- data_in  out  8  register write data
- busy  out  1  high in FETCH, LATCH and EXEC
- halted  out  1  high in HALT
- zero_flag  out  1  registered ALU zero
- carry_flag  out  1  registered ALU carry
- retired  out  16  count of executed instructions, wraps

## Operation
Instruction kinds, selected by ir[15:14]:
- 00 ALU: opcode = ir[13:11], rd_slct_a = ir[10:8], rd_slct_b = ir[7:5], bank = ir[4], idx = ir[3:1]. ir[0] is reserved and ignored. data_in = alu_c.
- 01 LDI: bank = ir[13], idx = ir[12:10], data_in = ir[7:0].
- 10 BR: branch to ir[7:0]. ir[13] = 0 tests zero_flag; ir[13] = 1 tests carry_flag. Taken when the flag is 1. No write.
- 11 HALT.

State machine IDLE, FETCH, LATCH, EXEC, HALT:
- IDLE or HALT, start = 1: pc <= 0, go to FETCH.
- FETCH: instr_addr = pc, go to LATCH.
- LATCH: ir <= instr_rdata, go to EXEC.
- EXEC, ALU/LDI/BR: drive decoded outputs, retired += 1, go to FETCH.
- EXEC, HALT: retired += 1, go to HALT.

Next-pc rules:
- pc <= pc+1, wrapping 255 -> 0.
- A taken BR loads its target instead.
- HALT leaves pc unchanged.

Output rules:
- wrtnbl = 1 only in EXEC for ALU/LDI.
- Flags update only at the end of an ALU EXEC, from alu_zero/alu_carry. LDI and BR leave them unchanged.
- Outside EXEC: rd_slct_a = rd_slct_b = 3'b010, opcode = 3'b000, wrtnbl = 0. This confines the register file's select-0 (zero) and select-1 (RNG) side-effects to the instruction that names them.
- Writes to idx 0/1 are issued as decoded. The register file's read-side overrides may clobber them; this is not the sequencer's concern.

## Timing
- Every instruction takes 3 cycles: FETCH, LATCH, EXEC.
- The register write and the flag capture both happen on the rising edge that ends EXEC.
- A BR to address X puts X on instr_addr in the next FETCH, 1 cycle after EXEC.
- instr_addr = pc in all states.
- start asserted while busy = 1 has no effect.
- Reset values:
  - state IDLE, pc 0, ir 16'hC000.
  - zero_flag = carry_flag = 0, retired 0.
  - busy 0, halted 0, wrtnbl 0.
  - data_in 0, wrt_slct 0, selects 3'b010, opcode 0.
- rst asserted mid-instruction: all of the above apply immediately. Any EXEC write in progress is suppressed because wrtnbl drops asynchronously.

## Structure
- marauder_pkg holds:
  - state_t enum
  - kind_t enum (K_ALU, K_LDI, K_BR, K_HALT)
  - instruction field position constants
  - IDLE_SEL = 3'b010
  - bank constants BANK_A = 0, BANK_B = 1
- One combinational sub-module, marauder_decode: maps ir to kind, selects, opcode, bank/idx and imm. marauder_seq instantiates it and applies state gating.

## Test plan
- Reset: rst pulse mid-FETCH -> all outputs at reset values; state IDLE; no wrtnbl pulse.
- LDI: ROM[0] = 16'h4805, start -> in the 3rd cycle wrtnbl = 1, wrt_slct = 7'h02, data_in = 8'h05; retired = 1.
- ALU: ROM[0] = 16'h0278 with alu_c = 8'h09, alu_zero = 0, alu_carry = 1 -> EXEC shows opcode 0, rd_slct_a = 2, rd_slct_b = 3, wrt_slct = 7'h0C, data_in = 8'h09; afterwards carry_flag = 1, zero_flag = 0.
- Branch: with zero_flag = 1, BR 16'h8010 -> next instr_addr = 8'h10. With zero_flag = 0 -> pc + 1. 16'hA010 follows carry_flag in the same way.
- HALT: ROM[2] = 16'hC000 -> halted = 1 after the 9th cycle, pc = 2, retired = 3. A start pulse then restarts at pc 0.
- Wrap: pc = 255 executing LDI -> next instr_addr = 0. start asserted during busy -> no effect.
